// File: rtl/alu_result_fifo.sv
// alu_result_fifo: registered result stage behind the 8-bit combinational ALU.
// Each accepted ALU result is stored with its opcode and two status flags
// (zero, hi-byte-nonzero) in a DEPTH-entry FIFO. The consumer reads the head
// entry through a valid/ready handshake.
//
// Optional feature (macro ALU_RES_ACC_EN): adds a 24-bit running sum of popped
// results (acc) with a clear input (acc_clr). Without the macro the FIFO is
// complete and behaves identically, minus those two ports.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer of valid keeps its data
// stable until that transfer; ready may change freely. Neither ready output
// depends combinationally on the opposite side's valid or ready.

module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [2:0]    in_op,
    input  logic [15:0]   in_r,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_op,
    output logic [15:0]   out_r,
    output logic          out_zero,
    output logic          out_hi,
    output logic [CW-1:0] count
`ifdef ALU_RES_ACC_EN
    ,
    output logic [23:0]   acc,
    input  logic          acc_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // One stored entry: flags are frozen at push time, never recomputed.
    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] r;
        logic        zero;
        logic        hi;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    entry_t        w_in_entry;
    entry_t        w_head;

    // Status decode. in_ready looks only at registered count and rst_n, so
    // there is no pass-through from out_ready when full.
    assign w_full    = (r_count == FULL_COUNT);
    assign in_ready  = rst_n && !w_full;
    assign out_valid = (r_count != '0);

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Entry built from the ALU result; hi means the result needed more than
    // 8 bits.
    assign w_in_entry.op   = in_op;
    assign w_in_entry.r    = in_r;
    assign w_in_entry.zero = (in_r == 16'd0);
    assign w_in_entry.hi   = (in_r[15:8] != 8'd0);

    // Head of queue drives the outputs directly; stale when empty.
    assign w_head   = r_mem[r_rd_ptr];
    assign out_op   = w_head.op;
    assign out_r    = w_head.r;
    assign out_zero = w_head.zero;
    assign out_hi   = w_head.hi;
    assign count    = r_count;

    // Storage array: cleared on reset, written at the write pointer on push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // Write pointer: advances on every accepted push, wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
        end
    end

    // Read pointer: advances on every completed pop, wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Occupancy: unchanged when push and pop coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

`ifdef ALU_RES_ACC_EN
    logic [23:0] r_acc;
    logic [23:0] w_head_ext;

    assign w_head_ext = {8'd0, w_head.r};
    assign acc        = r_acc;

    // Running sum of popped results, modulo 2^24. A clear together with a
    // pop restarts the sum at the popped value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_pop && acc_clr) begin
            r_acc <= w_head_ext;
        end else if (w_pop) begin
            r_acc <= r_acc + w_head_ext;
        end else if (acc_clr) begin
            r_acc <= '0;
        end
    end
`endif

endmodule
